// File: rtl/mem_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_initiator
// Brief    : Command-queued initiator for the PicoRV32 native memory bus.
//            Issues one access at a time and returns a response per command.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_initiator #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_instr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
);

  localparam int          c_ptr_w        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] c_timeout_last = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  c_err_ok       = 2'b00;
  localparam logic [1:0]  c_err_misalign = 2'b01;
  localparam logic [1:0]  c_err_timeout  = 2'b10;

  typedef struct packed {
    logic        write;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  cmd_t               r_fifo [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic [c_ptr_w:0]   w_count_nxt;
  logic               r_cmd_ready;
  state_t             r_state;
  logic               r_is_write;
  logic [31:0]        r_wait;
  logic               w_push;
  logic               w_pop;
  cmd_t               w_cmd;
  cmd_t               w_head;

  assign cmd_ready = r_cmd_ready;
  assign w_push    = cmd_valid && r_cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_cmd     = '{write: cmd_write, instr: cmd_instr, addr: cmd_addr,
                       wdata: cmd_wdata, wstrb: cmd_wstrb};

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + (c_ptr_w+1)'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - (c_ptr_w+1)'(1);
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= w_cmd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != (c_ptr_w+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_wait     <= '0;
      mem_valid  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= c_err_ok;
      rd_count   <= '0;
      wr_count   <= '0;
      err_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_head.addr[1:0] != 2'b00) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= c_err_misalign;
              err_count <= err_count + 32'd1;
            end else begin
              r_state    <= S_BUS;
              r_is_write <= w_head.write;
              r_wait     <= '0;
              mem_valid  <= 1'b1;
              mem_addr   <= w_head.addr;
              mem_wdata  <= w_head.wdata;
              mem_wstrb  <= w_head.write ? w_head.wstrb : 4'b0000;
              mem_instr  <= w_head.write ? 1'b0 : w_head.instr;
            end
          end
        end
        S_BUS: begin
          // A ready on the timeout edge still counts as a completed access.
          if (mem_ready) begin
            r_state   <= S_RESP;
            mem_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= c_err_ok;
            rsp_rdata <= r_is_write ? 32'd0 : mem_rdata;
            if (r_is_write) wr_count <= wr_count + 32'd1;
            else            rd_count <= rd_count + 32'd1;
          end else if ((TIMEOUT_CYCLES != 0) && (r_wait == c_timeout_last)) begin
            r_state   <= S_RESP;
            mem_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= c_err_timeout;
            rsp_rdata <= '0;
            err_count <= err_count + 32'd1;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state   <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_initiator
// Brief    : Directed bench for mem_bus_initiator against a simple responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_instr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] rd_count, wr_count, err_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Responder state
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] bus_log [$];
  int          resp_wait   = 1;
  bit          resp_hang   = 1'b0;
  int          wait_cnt    = 0;
  int          valid_cycles = 0;
  int          vc_snap     = 0;
  bit          instr_seen  = 1'b0;
  logic [3:0]  last_wstrb  = 4'b0;

  logic [31:0] rd;
  logic [1:0]  er;

  mem_bus_initiator #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_instr(cmd_instr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Memory responder: drives mem_ready on the falling edge after the wait states.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_valid === 1'b1) begin
        valid_cycles++;
        last_wstrb = mem_wstrb;
        if (mem_instr === 1'b1) instr_seen = 1'b1;
      end
      if (mem_valid === 1'b1 && !mem_ready && !resp_hang) begin
        if (wait_cnt >= resp_wait) begin
          logic [31:0] cur;
          cur = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'd0;
          for (int i = 0; i < 4; i++)
            if (mem_wstrb[i]) cur[8*i +: 8] = mem_wdata[8*i +: 8];
          if (mem_wstrb != 4'b0) mem_model[mem_addr] = cur;
          mem_rdata = cur;
          mem_ready = 1'b1;
          bus_log.push_back(mem_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic w, input logic ins, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int k = 0;
    cmd_write = w; cmd_instr = ins; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (cmd_ready !== 1'b1) check("push_stall", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] r, output logic [1:0] e);
    int k = 0;
    rsp_ready = 1'b1;
    while (rsp_valid !== 1'b1 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    if (rsp_valid !== 1'b1) check("rsp_wait", 32'(rsp_valid), 32'd1);
    r = rsp_rdata;
    e = rsp_err;
    vc_snap = valid_cycles;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_instr = 1'b0;
    cmd_addr = 32'd0; cmd_wdata = 32'd0; cmd_wstrb = 4'd0; rsp_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_counts", rd_count | wr_count | err_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Write then read back, one wait state
    resp_wait = 1;
    push(1'b1, 1'b0, 32'h1000, 32'hDEADBEEF, 4'hF);
    get_rsp(rd, er);
    check("wr_rsp_err", 32'(er), 32'd0);
    check("wr_rsp_rdata", rd, 32'd0);
    push(1'b0, 1'b0, 32'h1000, 32'd0, 4'h0);
    get_rsp(rd, er);
    check("rd_rsp_err", 32'(er), 32'd0);
    check("rd_rsp_rdata", rd, 32'hDEADBEEF);
    check("wr_count_1", wr_count, 32'd1);
    check("rd_count_1", rd_count, 32'd1);

    // Byte strobe write
    mem_model[32'h2000] = 32'h11223344;
    instr_seen = 1'b0;
    push(1'b1, 1'b0, 32'h2000, 32'h000000AA, 4'h1);
    get_rsp(rd, er);
    check("strobe_bus_wstrb", 32'(last_wstrb), 32'h1);
    push(1'b0, 1'b0, 32'h2000, 32'hFFFFFFFF, 4'hF);
    get_rsp(rd, er);
    check("strobe_read_wstrb", 32'(last_wstrb), 32'h0);
    check("strobe_rdata", rd, 32'h112233AA);
    check("strobe_no_instr", 32'(instr_seen), 32'd0);

    // Misaligned read
    valid_cycles = 0;
    push(1'b0, 1'b0, 32'h1002, 32'd0, 4'h0);
    get_rsp(rd, er);
    check("misalign_err", 32'(er), 32'd1);
    check("misalign_rdata", rd, 32'd0);
    check("misalign_no_bus", 32'(vc_snap), 32'd0);
    check("misalign_err_count", err_count, 32'd1);

    // Timeout, then a queued command proceeds normally
    resp_hang = 1'b1;
    valid_cycles = 0;
    push(1'b0, 1'b0, 32'h3000, 32'd0, 4'h0);
    push(1'b0, 1'b0, 32'h1000, 32'd0, 4'h0);
    get_rsp(rd, er);
    resp_hang = 1'b0;
    check("timeout_err", 32'(er), 32'd2);
    check("timeout_rdata", rd, 32'd0);
    check("timeout_valid_cycles", 32'(vc_snap), 32'd8);
    check("timeout_err_count", err_count, 32'd2);
    get_rsp(rd, er);
    check("after_timeout_err", 32'(er), 32'd0);
    check("after_timeout_rdata", rd, 32'hDEADBEEF);
    check("after_timeout_rd_count", rd_count, 32'd3);

    // FIFO full with response backpressure
    mem_model[32'h1004] = 32'hCAFE0004;
    mem_model[32'h1008] = 32'hCAFE0008;
    mem_model[32'h100C] = 32'hCAFE000C;
    bus_log.delete();
    instr_seen = 1'b0;
    push(1'b0, 1'b0, 32'h1000, 32'd0, 4'h0);
    push(1'b0, 1'b1, 32'h2000, 32'd0, 4'h0);
    push(1'b0, 1'b0, 32'h1004, 32'd0, 4'h0);
    push(1'b0, 1'b0, 32'h1008, 32'd0, 4'h0);
    push(1'b0, 1'b0, 32'h100C, 32'd0, 4'h0);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("full_hold_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_hold_rsp_valid", 32'(rsp_valid), 32'd1);
    get_rsp(rd, er); check("ord_rdata0", rd, 32'hDEADBEEF);
    get_rsp(rd, er); check("ord_rdata1", rd, 32'h112233AA);
    get_rsp(rd, er); check("ord_rdata2", rd, 32'hCAFE0004);
    get_rsp(rd, er); check("ord_rdata3", rd, 32'hCAFE0008);
    get_rsp(rd, er); check("ord_rdata4", rd, 32'hCAFE000C);
    check("ord_log_size", 32'(bus_log.size()), 32'd5);
    if (bus_log.size() == 5) begin
      check("ord_addr0", bus_log[0], 32'h1000);
      check("ord_addr1", bus_log[1], 32'h2000);
      check("ord_addr4", bus_log[4], 32'h100C);
    end
    check("fetch_instr_seen", 32'(instr_seen), 32'd1);
    check("final_rd_count", rd_count, 32'd8);
    check("final_wr_count", wr_count, 32'd2);

    // Reset during an active bus access
    resp_hang = 1'b1;
    push(1'b0, 1'b0, 32'h1000, 32'd0, 4'h0);
    for (int k = 0; k < 20 && mem_valid !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    check("midbus_valid_before", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midbus_mem_valid", 32'(mem_valid), 32'd0);
    check("midbus_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midbus_counts", rd_count | wr_count | err_count, 32'd0);
    reset = 1'b0;
    resp_hang = 1'b0;
    rsp_ready = 1'b1;
    begin
      bit seen_rsp = 1'b0;
      bit seen_bus = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        if (rsp_valid === 1'b1) seen_rsp = 1'b1;
        if (mem_valid === 1'b1) seen_bus = 1'b1;
      end
      check("midbus_no_rsp", 32'(seen_rsp), 32'd0);
      check("midbus_no_bus", 32'(seen_bus), 32'd0);
    end
    check("midbus_cmd_ready", 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
